// File: rtl/load_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_seq_pkg
// Description : Shared types and constants for the storage load sequencer.
//               Holds the command opcode enum, the sequencer state enum,
//               default data-word geometry and a lane-extraction helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package load_seq_pkg;

    localparam int DEF_LANES  = 3;
    localparam int DEF_LANE_W = 16;
    localparam int DW         = DEF_LANES * DEF_LANE_W;
    localparam int OP_W       = 3;

    // Command opcodes; encodings 6 and 7 are illegal.
    typedef enum logic [OP_W-1:0] {
        OP_WR_WEIGHT = 3'd0,
        OP_WR_INPUT  = 3'd1,
        OP_WR_LABEL  = 3'd2,
        OP_WR_CODE   = 3'd3,
        OP_START     = 3'd4,
        OP_STOP      = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_LOC_RST = 3'd2,
        ST_ARM     = 3'd3,
        ST_RUN     = 3'd4
    } state_e;

    // Lane i of a default-geometry row word; lane 0 sits in the MSBs.
    function automatic logic [DEF_LANE_W-1:0] lane(input logic [DW-1:0] word,
                                                   input int unsigned i);
        logic [DW-1:0] shifted;
        shifted = word << (i * DEF_LANE_W);
        return shifted[DW-1 -: DEF_LANE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_seq_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : load_seq_beat_counter
// Description : Row/line address generator for one load command. Latches the
//               first row and the beat count on i_start, advances on each
//               accepted beat, and flags the final beat.
// Ports       : clk          - clock
//               rst_n        - synchronous active-low reset
//               i_start      - latch i_row / i_count (new load command)
//               i_row        - first row index of the command
//               i_count      - number of beats in the command (non-zero)
//               i_beat       - a data beat is accepted this cycle
//               o_row        - row index for the beat being accepted
//               o_last_beat  - the beat being accepted is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module load_seq_beat_counter #(
    parameter int IDX_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [IDX_W-1:0] i_row,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_beat,
    output logic [IDX_W-1:0] o_row,
    output logic             o_last_beat
);

    logic [IDX_W-1:0] r_base;
    logic [IDX_W-1:0] r_offset;
    logic [CNT_W-1:0] r_remaining;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_offset    <= '0;
            r_remaining <= '0;
        end else if (i_start) begin
            r_base      <= i_row;
            r_offset    <= '0;
            r_remaining <= i_count;
        end else if (i_beat) begin
            r_offset    <= r_offset + IDX_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Row arithmetic wraps modulo 2^IDX_W by construction.
    assign o_row       = r_base + r_offset;
    assign o_last_beat = (r_remaining == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/storage_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : storage_load_sequencer
// Description : Command/data stream loader for data_path. Writes weight,
//               input, label and code storages through a shared registered
//               write bus, then sequences locator reset, code-storage enable
//               and controller enable on START; STOP drops both enables.
// Ports       : clk_clk, reset_reset_n       - clock, sync active-low reset
//               cmd_valid/ready, cmd_op, cmd_layer, cmd_row, cmd_count
//                                            - command stream
//               data_valid/ready, data_word  - row data stream
//               wr_layer_index, wr_row_index, wr_data - shared write bus
//               weight/input/label/code_is_write      - write strobes
//               locator_reset, code_enable, controller_enable - run control
//               busy, load_done, error       - status
// Revision    : 1.0 - initial release
// ============================================================================
module storage_load_sequencer
    import load_seq_pkg::*;
#(
    parameter int LANES  = 3,
    parameter int LANE_W = 16,
    parameter int IDX_W  = 32,
    parameter int CODE_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OP_W-1:0]         cmd_op,
    input  logic [IDX_W-1:0]        cmd_layer,
    input  logic [IDX_W-1:0]        cmd_row,
    input  logic [CNT_W-1:0]        cmd_count,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic [LANES*LANE_W-1:0] data_word,
    output logic [IDX_W-1:0]        wr_layer_index,
    output logic [IDX_W-1:0]        wr_row_index,
    output logic [LANES*LANE_W-1:0] wr_data,
    output logic                    weight_is_write,
    output logic                    input_is_write,
    output logic                    label_is_write,
    output logic                    code_is_write,
    output logic                    locator_reset,
    output logic                    code_enable,
    output logic                    controller_enable,
    output logic                    busy,
    output logic                    load_done,
    output logic                    error
);

    localparam int DATA_W = LANES * LANE_W;

    // Code storage consumes the low CODE_W bits of the shared data bus.
    if (CODE_W > DATA_W) begin : g_code_w_check
        $error("CODE_W must not exceed LANES*LANE_W");
    end

    state_e           r_state;
    state_e           w_next_state;
    logic             w_cmd_ready;
    logic             w_data_ready;
    logic             w_load_start;
    logic             w_beat;
    logic             w_err_set;
    logic [IDX_W-1:0] w_cur_row;
    logic             w_last_beat;

    op_e              r_op;
    logic [IDX_W-1:0] r_layer;
    logic [IDX_W-1:0] r_wr_layer;
    logic [IDX_W-1:0] r_wr_row;
    logic [DATA_W-1:0] r_wr_data;
    logic             r_weight_wr;
    logic             r_input_wr;
    logic             r_label_wr;
    logic             r_code_wr;
    logic             r_load_done;
    logic             r_locator_reset;
    logic             r_code_en;
    logic             r_ctrl_en;
    logic             r_error;

    load_seq_beat_counter #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .i_start     (w_load_start),
        .i_row       (cmd_row),
        .i_count     (cmd_count),
        .i_beat      (w_beat),
        .o_row       (w_cur_row),
        .o_last_beat (w_last_beat)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_data_ready = 1'b0;
        w_load_start = 1'b0;
        w_beat       = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WR_WEIGHT, OP_WR_INPUT, OP_WR_LABEL, OP_WR_CODE: begin
                            // A zero-length load is consumed without leaving IDLE.
                            if (cmd_count != '0) begin
                                w_load_start = 1'b1;
                                w_next_state = ST_LOAD;
                            end
                        end
                        OP_START: w_next_state = ST_LOC_RST;
                        OP_STOP:  w_next_state = ST_IDLE;
                        default:  w_err_set    = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                w_data_ready = 1'b1;
                if (data_valid) begin
                    w_beat = 1'b1;
                    if (w_last_beat) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_LOC_RST: w_next_state = ST_ARM;
            ST_ARM:     w_next_state = ST_RUN;
            ST_RUN: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Storages must not change under a running controller:
                    // anything other than STOP is dropped and flagged.
                    if (cmd_op == OP_STOP) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered write bus, strobes and run-control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_op            <= OP_WR_WEIGHT;
            r_layer         <= '0;
            r_wr_layer      <= '0;
            r_wr_row        <= '0;
            r_wr_data       <= '0;
            r_weight_wr     <= 1'b0;
            r_input_wr      <= 1'b0;
            r_label_wr      <= 1'b0;
            r_code_wr       <= 1'b0;
            r_load_done     <= 1'b0;
            r_locator_reset <= 1'b0;
            r_code_en       <= 1'b0;
            r_ctrl_en       <= 1'b0;
            r_error         <= 1'b0;
        end else begin
            r_weight_wr <= 1'b0;
            r_input_wr  <= 1'b0;
            r_label_wr  <= 1'b0;
            r_code_wr   <= 1'b0;
            r_load_done <= 1'b0;

            if (w_load_start) begin
                r_op    <= op_e'(cmd_op);
                r_layer <= cmd_layer;
            end

            // Bus fields only move with a strobe, so they hold otherwise.
            if (w_beat) begin
                r_wr_layer  <= r_layer;
                r_wr_row    <= w_cur_row;
                r_wr_data   <= data_word;
                r_load_done <= w_last_beat;
                case (r_op)
                    OP_WR_WEIGHT: r_weight_wr <= 1'b1;
                    OP_WR_INPUT:  r_input_wr  <= 1'b1;
                    OP_WR_LABEL:  r_label_wr  <= 1'b1;
                    OP_WR_CODE:   r_code_wr   <= 1'b1;
                    default:      r_weight_wr <= 1'b0;
                endcase
            end

            // Enables are decoded from the next state so they change on
            // the same edge as the state transition.
            r_locator_reset <= (w_next_state == ST_LOC_RST);
            r_code_en       <= (w_next_state == ST_ARM) || (w_next_state == ST_RUN);
            r_ctrl_en       <= (w_next_state == ST_RUN);

            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    assign cmd_ready         = w_cmd_ready;
    assign data_ready        = w_data_ready;
    assign wr_layer_index    = r_wr_layer;
    assign wr_row_index      = r_wr_row;
    assign wr_data           = r_wr_data;
    assign weight_is_write   = r_weight_wr;
    assign input_is_write    = r_input_wr;
    assign label_is_write    = r_label_wr;
    assign code_is_write     = r_code_wr;
    assign locator_reset     = r_locator_reset;
    assign code_enable       = r_code_en;
    assign controller_enable = r_ctrl_en;
    assign busy              = (r_state != ST_IDLE);
    assign load_done         = r_load_done;
    assign error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_storage_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_storage_load_sequencer
// Description : Self-checking bench for storage_load_sequencer. Directed
//               scenarios followed by randomized command/data traffic, all
//               compared every cycle against a transaction-level model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_storage_load_sequencer;
    import load_seq_pkg::*;

    localparam int IDX_W = 32;
    localparam int CNT_W = 16;
    localparam int DWB   = 48;

    // Model phases named after the sequencer's documented behaviour.
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_LRST = 2;
    localparam int M_ARM  = 3;
    localparam int M_RUN  = 4;

    logic             clk_clk = 1'b0;
    logic             reset_reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [IDX_W-1:0] cmd_layer;
    logic [IDX_W-1:0] cmd_row;
    logic [CNT_W-1:0] cmd_count;
    logic             data_valid;
    logic             data_ready;
    logic [DWB-1:0]   data_word;
    logic [IDX_W-1:0] wr_layer_index;
    logic [IDX_W-1:0] wr_row_index;
    logic [DWB-1:0]   wr_data;
    logic             weight_is_write, input_is_write, label_is_write, code_is_write;
    logic             locator_reset, code_enable, controller_enable;
    logic             busy, load_done, error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               m_mode  = M_IDLE;
    bit               m_known = 1'b0;
    int               m_op;
    int               m_left;
    logic [IDX_W-1:0] m_layer;
    logic [IDX_W-1:0] m_next_row;
    logic [IDX_W-1:0] e_layer, e_row;
    logic [DWB-1:0]   e_data;
    logic [3:0]       e_strb;
    logic             e_done, e_err;

    storage_load_sequencer dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_layer         (cmd_layer),
        .cmd_row           (cmd_row),
        .cmd_count         (cmd_count),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .data_word         (data_word),
        .wr_layer_index    (wr_layer_index),
        .wr_row_index      (wr_row_index),
        .wr_data           (wr_data),
        .weight_is_write   (weight_is_write),
        .input_is_write    (input_is_write),
        .label_is_write    (label_is_write),
        .code_is_write     (code_is_write),
        .locator_reset     (locator_reset),
        .code_enable       (code_enable),
        .controller_enable (controller_enable),
        .busy              (busy),
        .load_done         (load_done),
        .error             (error)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DWB-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DWB-1:0];
    endfunction

    // One clock cycle: predict from current inputs, advance, then compare.
    task automatic tick();
        logic exp_cr, exp_dr, chs, dhs;
        int   nmode;
        exp_cr = 1'b0;
        exp_dr = 1'b0;
        if (m_known) begin
            exp_cr = (m_mode == M_IDLE) || (m_mode == M_RUN);
            exp_dr = (m_mode == M_LOAD);
            check("cmd_ready", {63'd0, cmd_ready}, {63'd0, exp_cr});
            check("data_ready", {63'd0, data_ready}, {63'd0, exp_dr});
        end
        chs    = cmd_valid && exp_cr;
        dhs    = data_valid && exp_dr;
        e_strb = 4'b0000;
        e_done = 1'b0;
        nmode  = m_mode;
        if (!reset_reset_n) begin
            nmode   = M_IDLE;
            e_err   = 1'b0;
            e_layer = '0;
            e_row   = '0;
            e_data  = '0;
            m_known = 1'b1;
        end else begin
            if (m_mode == M_IDLE && chs) begin
                if (cmd_op <= 3'd3) begin
                    if (cmd_count != 0) begin
                        m_op       = int'(cmd_op);
                        m_left     = int'(cmd_count);
                        m_layer    = cmd_layer;
                        m_next_row = cmd_row;
                        nmode      = M_LOAD;
                    end
                end else if (cmd_op == 3'd4) nmode = M_LRST;
                else if (cmd_op != 3'd5)     e_err = 1'b1;
            end else if (m_mode == M_LOAD && dhs) begin
                e_strb     = 4'b1000 >> m_op;
                e_layer    = m_layer;
                e_row      = m_next_row;
                e_data     = data_word;
                m_next_row = m_next_row + 1;
                m_left     = m_left - 1;
                if (m_left == 0) begin
                    e_done = 1'b1;
                    nmode  = M_IDLE;
                end
            end else if (m_mode == M_LRST) nmode = M_ARM;
            else if (m_mode == M_ARM)      nmode = M_RUN;
            else if (m_mode == M_RUN && chs) begin
                if (cmd_op == 3'd5) nmode = M_IDLE;
                else                e_err = 1'b1;
            end
        end
        m_mode = nmode;
        @(posedge clk_clk);
        #1;
        check("strobes", {60'd0, weight_is_write, input_is_write, label_is_write, code_is_write},
              {60'd0, e_strb});
        check("load_done", {63'd0, load_done}, {63'd0, e_done});
        check("wr_layer", {32'd0, wr_layer_index}, {32'd0, e_layer});
        check("wr_row", {32'd0, wr_row_index}, {32'd0, e_row});
        check("wr_data", {16'd0, wr_data}, {16'd0, e_data});
        check("locator_reset", {63'd0, locator_reset}, {63'd0, 1'(m_mode == M_LRST)});
        check("code_enable", {63'd0, code_enable},
              {63'd0, 1'(m_mode == M_ARM || m_mode == M_RUN)});
        check("controller_enable", {63'd0, controller_enable}, {63'd0, 1'(m_mode == M_RUN)});
        check("busy", {63'd0, busy}, {63'd0, 1'(m_mode != M_IDLE)});
        check("error", {63'd0, error}, {63'd0, e_err});
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [IDX_W-1:0] layer,
                            input logic [IDX_W-1:0] row, input logic [CNT_W-1:0] count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_layer = layer;
        cmd_row   = row;
        cmd_count = count;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic [DWB-1:0] w);
        data_valid = 1'b1;
        data_word  = w;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [DWB-1:0] w1;
        reset_reset_n = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = '0;
        cmd_layer  = '0;
        cmd_row    = '0;
        cmd_count  = '0;
        data_valid = 1'b0;
        data_word  = '0;
        e_layer = '0; e_row = '0; e_data = '0; e_err = 1'b0;

        // Reset state
        idle(2);
        reset_reset_n = 1'b1;
        idle(1);

        // Weight load: three back-to-back beats at rows 5..7 of layer 2
        send_cmd(3'd0, 32'd2, 32'd5, 16'd3);
        beat(48'h0001_0002_0003);
        check("wt_lane0", {48'd0, lane(wr_data, 0)}, 64'h0001);
        check("wt_lane2", {48'd0, lane(wr_data, 2)}, 64'h0003);
        beat(48'h0004_0005_0006);
        beat(48'h0007_0008_0009);
        check("wt_last_row", {32'd0, wr_row_index}, 64'd7);
        check("wt_done", {63'd0, load_done}, 64'd1);
        idle(1);

        // Code load with a one-cycle data gap
        send_cmd(3'd3, 32'd9, 32'd0, 16'd2);
        beat(48'h1111_2222_3ABC);
        idle(1);
        w1 = 48'h4444_5555_6DEF;
        beat(w1);
        check("code_low", {52'd0, wr_data[11:0]}, {52'd0, w1[11:0]});

        // Input load wrapping the row index; then a zero-length label load
        send_cmd(3'd1, 32'd1, 32'hFFFF_FFFF, 16'd2);
        beat(rnd48());
        check("wrap_row0", {32'd0, wr_row_index}, 64'hFFFF_FFFF);
        beat(rnd48());
        check("wrap_row1", {32'd0, wr_row_index}, 64'd0);
        send_cmd(3'd2, 32'd3, 32'd4, 16'd0);
        check("cnt0_idle", {63'd0, busy}, 64'd0);

        // Start sequence, illegal traffic while running, then stop
        send_cmd(3'd4, '0, '0, '0);
        check("start_lrst", {63'd0, locator_reset}, 64'd1);
        idle(1);
        check("start_arm", {62'd0, code_enable, controller_enable}, 64'b10);
        idle(1);
        check("start_run", {62'd0, code_enable, controller_enable}, 64'b11);
        send_cmd(3'd2, 32'd1, 32'd1, 16'd4);
        send_cmd(3'd7, '0, '0, '0);
        check("run_err", {63'd0, error}, 64'd1);
        idle(2);
        send_cmd(3'd5, '0, '0, '0);
        check("stop_off", {61'd0, code_enable, controller_enable, busy}, 64'd0);

        // Reset during a load after one of four beats
        reset_reset_n = 1'b0;
        idle(1);
        reset_reset_n = 1'b1;
        send_cmd(3'd0, 32'd6, 32'd10, 16'd4);
        beat(rnd48());
        reset_reset_n = 1'b0;
        data_valid    = 1'b1;
        data_word     = rnd48();
        tick();
        reset_reset_n = 1'b1;
        tick();
        tick();
        data_valid = 1'b0;
        check("rst_quiet", {16'd0, wr_data}, 64'd0);
        send_cmd(3'd1, 32'd8, 32'd20, 16'd1);
        check("fresh_busy", {63'd0, busy}, 64'd1);
        beat(rnd48());
        check("fresh_done", {63'd0, input_is_write, load_done}, 64'b11);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            int r;
            int n;
            r = $urandom_range(9, 0);
            if (r < 7) begin
                n = $urandom_range(5, 0);
                send_cmd(3'($urandom_range(3, 0)), $urandom(),
                         (r == 6) ? 32'hFFFF_FFFE : $urandom(), CNT_W'(n));
                for (int k = 0; k < n; k++) begin
                    int g;
                    g = $urandom_range(2, 0);
                    idle(g);
                    beat(rnd48());
                end
            end else if (r == 7) begin
                send_cmd(3'd4, '0, '0, '0);
                idle($urandom_range(4, 2));
                if ($urandom_range(1, 0) == 1) send_cmd(3'($urandom_range(4, 0)), $urandom(), $urandom(), 16'd2);
                idle(1);
                send_cmd(3'd5, '0, '0, '0);
            end else begin
                data_valid = 1'b1;
                data_word  = rnd48();
                send_cmd((r == 9) ? 3'd5 : 3'd6, '0, '0, '0);
                data_valid = 1'b0;
            end
        end

        // Reset while running drops both enables
        send_cmd(3'd4, '0, '0, '0);
        idle(3);
        reset_reset_n = 1'b0;
        idle(1);
        reset_reset_n = 1'b1;
        check("rst_run", {60'd0, code_enable, controller_enable, busy, error}, 64'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/storage_load_sequencer.md
Name: storage_load_sequencer

Overview:
Synthesisable loader that replaces file-driven stimulus for data_path. It takes a command stream plus a data stream and drives the write interfaces of the weight, input, label and code storages. It then runs the start sequence: matrix locator reset, then code_storage enable, then controller enable one cycle later. It sits between a host/DMA front end and data_path, and is generalised in lane count, lane width and index width.

Parameters:
LANES, 3, number of fixed-point lanes per row word
LANE_W, 16, bits per lane; data word width DW = LANES*LANE_W
IDX_W, 32, width of layer/row/line indices
CODE_W, 12, code-storage instruction width (CODE_W <= DW)
CNT_W, 16, width of the row-count field in a command

Ports:
clk_clk  in  1  clock
reset_reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  3  0 WR_WEIGHT, 1 WR_INPUT, 2 WR_LABEL, 3 WR_CODE, 4 START, 5 STOP, 6-7 illegal
cmd_layer  in  IDX_W  target layer index (ignored for WR_CODE)
cmd_row  in  IDX_W  first row index / first code line
cmd_count  in  CNT_W  number of data beats that follow
data_valid  in  1  data beat offered
data_ready  out  1  data beat accepted when valid&ready
data_word  in  DW  row data, lane 0 in the MSBs
wr_layer_index  out  IDX_W  shared write layer index
wr_row_index  out  IDX_W  shared write row index / code line
wr_data  out  DW  shared write data; code storage uses wr_data[CODE_W-1:0]
weight_is_write, input_is_write, label_is_write, code_is_write  out  1 each  one-cycle write strobes
locator_reset  out  1  to matrix_storage_locator_reset_interface_reset
code_enable  out  1  to code_storage_enable_interface_enable
controller_enable  out  1  to controller_enable_interface_enable
busy  out  1  high in any state except IDLE
load_done  out  1  one-cycle pulse with the last write strobe of a command
error  out  1  sticky; cleared only by reset

Behaviour:
- Reset (synchronous, reset_reset_n=0 at a clk_clk edge): state IDLE. All outputs 0, including indices, data and error. In-flight load is discarded with no partial strobe. Reset mid-RUN drops both enables on the next edge.
- FSM states: IDLE, LOAD, LOC_RST, ARM, RUN.
- IDLE: cmd_ready=1, data_ready=0.
  - WR_* with count=0: consumed, no writes, stay IDLE.
  - WR_* with count>0: latch op, layer, row and count; go to LOAD.
  - START: go to LOC_RST.
  - STOP: no-op.
  - Illegal op: consumed, error=1.
- LOAD: cmd_ready=0, data_ready=1. Each accepted beat k (k=0..count-1) produces, on the next cycle, the target strobe=1, wr_row_index=row+k (mod 2^IDX_W), wr_layer_index=layer and wr_data=data_word.
  - Latency is exactly 1 cycle from handshake to strobe; strobes are registered.
  - data_valid low stalls with no strobe. Back-to-back beats give back-to-back strobes.
  - On the last beat's handshake the state goes to IDLE. load_done pulses with the last strobe.
  - A new command can be accepted in the same cycle the last strobe is visible.
- LOC_RST: locator_reset=1 for exactly 1 cycle, then ARM.
- ARM: code_enable=1 and controller_enable=0 for 1 cycle, then RUN.
- RUN: code_enable=1, controller_enable=1, cmd_ready=1, data_ready=0.
  - STOP: both enables drop on the next edge; return to IDLE.
  - WR_*, START or illegal op: consumed and discarded, error=1. Storages are never written while running.
- Only one strobe can be high at a time. Strobes are never high outside LOAD-driven cycles.
- busy=1 in LOAD, LOC_RST, ARM and RUN.
- wr_layer_index, wr_row_index and wr_data hold their last values when no strobe is active.

Decomposition:
- Package load_seq_pkg holds:
  - op enum (WR_WEIGHT..STOP)
  - FSM state enum
  - localparams DW and OP_W=3
  - helper function lane(word, i) for bench checking
- One natural sub-module, load_seq_beat_counter: holds row base plus offset and the remaining-count register, and outputs last_beat and the current row. The FSM, strobe decode and enable sequencing stay in the top.

Test Plan:
- WR_WEIGHT layer=2 row=5 count=3, beats 0x0001_0002_0003 / 0x0004_0005_0006 / 0x0007_0008_0009 -> weight_is_write high for 3 consecutive cycles with rows 5,6,7, layer 2 and matching data; load_done on the third strobe; other strobes 0.
- WR_CODE row=0 count=2, data_valid toggled 1,0,1 -> code_is_write at lines 0 and 1 only, with wr_data[11:0] = beat low bits, and the gap reproduced.
- START from IDLE -> locator_reset=1 at cycle T+1; code_enable=1 from T+2; controller_enable=1 from T+3. STOP then drops both on the next edge with busy=0.
- WR_LABEL during RUN, then op=7 -> no strobe, error=1 and held; enables unaffected.
- WR_INPUT row=0xFFFFFFFF count=2 -> rows 0xFFFFFFFF, then 0x00000000. count=0 -> no strobe, stays IDLE.
- reset_reset_n=0 after 1 of 4 beats, then release -> no further strobes, all outputs 0, and a fresh command is accepted.
